dma_line_unpacker: RTL and testbench

- Sits between the host DMA read channel and the memory controller's DMA port.
- Pops 512-bit cache lines from the DMA read FIFO and serializes each line into 32-bit word writes to local memory at consecutive word addresses.
- Started by the MMIO go pulse; reports busy/done to the AFU control logic.

---
 rtl/dma_line_unpacker_if.sv | 36 +++
 rtl/dma_line_unpacker.sv | 177 +++++++++++++++++
 tb/tb_dma_line_unpacker.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_line_unpacker_if.sv
// DMA line unpacker bus: go/size control, DMA FIFO read side,
// memory write side and busy/done status. master = unpacker.
interface dma_line_unpacker_if #(
  parameter int CL_WIDTH   = 512,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 28,
  parameter int SIZE_WIDTH = 27
);
  logic                  go;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [SIZE_WIDTH-1:0] num_lines;
  logic                  dma_empty;
  logic [CL_WIDTH-1:0]   dma_rd_data;
  logic                  dma_rd_en;
  logic                  mem_ready;
  logic                  mem_en;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_data;
  logic                  busy;
  logic                  done;

  modport master (
    input  go, base_addr, num_lines,
    input  dma_empty, dma_rd_data, mem_ready,
    output dma_rd_en, mem_en, mem_wr_en,
    output mem_addr, mem_data, busy, done
  );

  modport slave (
    output go, base_addr, num_lines,
    output dma_empty, dma_rd_data, mem_ready,
    input  dma_rd_en, mem_en, mem_wr_en,
    input  mem_addr, mem_data, busy, done
  );
endinterface

// File: rtl/dma_line_unpacker.sv
// Pops cache lines from the DMA read FIFO and writes them out as
// consecutive memory words. Ports: clk, rst (sync, active high),
// bus (dma_line_unpacker_if.master: go/base_addr/num_lines in,
// dma_empty/dma_rd_data/dma_rd_en FIFO side, mem_* write side,
// busy/done status). Optional UNPACK_PREFETCH_EN adds a spare
// line buffer so lines stream back to back without a FETCH gap.
module dma_line_unpacker #(
  parameter int CL_WIDTH   = 512,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 28,
  parameter int SIZE_WIDTH = 27
) (
  input logic clk,
  input logic rst,
  dma_line_unpacker_if.master bus
);
  localparam int WORDS = CL_WIDTH / WORD_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SERIAL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CL_WIDTH-1:0]   r_buf;
  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SIZE_WIDTH-1:0] r_num;
  logic [SIZE_WIDTH-1:0] r_lines;

  logic w_go_acc;
  logic w_pop;
  logic w_accept;
  logic w_last;
  logic w_final;
  logic w_en;
  logic [WORD_WIDTH-1:0] w_word;

`ifdef UNPACK_PREFETCH_EN
  logic [CL_WIDTH-1:0]   r_nbuf;
  logic                  r_nvalid;
  logic [SIZE_WIDTH-1:0] r_pops;
  logic                  w_pref;
`endif

  assign w_last  = (r_idx == IDX_W'(WORDS - 1));
  assign w_final = ((r_lines + SIZE_WIDTH'(1)) == r_num);
  assign w_word  = r_buf[r_idx*WORD_WIDTH +: WORD_WIDTH];

  always_comb begin
    w_next   = r_state;
    w_go_acc = 1'b0;
    w_pop    = 1'b0;
    w_accept = 1'b0;
`ifdef UNPACK_PREFETCH_EN
    w_pref   = 1'b0;
`endif
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.go) begin
          w_go_acc = 1'b1;
          if (bus.num_lines == '0)
            w_next = S_DONE;
          else
            w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!bus.dma_empty) begin
          w_pop  = 1'b1;
          w_next = S_SERIAL;
        end
      end
      S_SERIAL: begin
        w_accept = bus.mem_ready;
`ifdef UNPACK_PREFETCH_EN
        // r_pops bounds total pops to the latched line count.
        w_pref = !bus.dma_empty && !r_nvalid
               && (r_pops != r_num);
        w_pop  = w_pref;
`endif
        if (w_accept && w_last) begin
          if (w_final)
            w_next = S_DONE;
`ifdef UNPACK_PREFETCH_EN
          else if (r_nvalid || w_pref)
            w_next = S_SERIAL;
`endif
          else
            w_next = S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Reset aborts at once: no pop or write in the reset cycle.
    if (rst) begin
      w_pop    = 1'b0;
      w_accept = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_num   <= '0;
      r_lines <= '0;
`ifdef UNPACK_PREFETCH_EN
      r_nbuf   <= '0;
      r_nvalid <= 1'b0;
      r_pops   <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_go_acc) begin
        r_addr  <= bus.base_addr;
        r_num   <= bus.num_lines;
        r_lines <= '0;
        r_idx   <= '0;
`ifdef UNPACK_PREFETCH_EN
        r_nvalid <= 1'b0;
        r_pops   <= '0;
`endif
      end
      if (w_accept) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
        if (w_last) begin
          r_idx   <= '0;
          r_lines <= r_lines + SIZE_WIDTH'(1);
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
`ifdef UNPACK_PREFETCH_EN
      // Swap in the spare line as the current one finishes.
      if (w_accept && w_last && r_nvalid && !w_final) begin
        r_buf    <= r_nbuf;
        r_nvalid <= 1'b0;
      end
      if (w_pop) begin
        r_pops <= r_pops + SIZE_WIDTH'(1);
        // A pop landing on the last accept feeds r_buf directly.
        if (r_state == S_SERIAL && !(w_accept && w_last)) begin
          r_nbuf   <= bus.dma_rd_data;
          r_nvalid <= 1'b1;
        end else begin
          r_buf <= bus.dma_rd_data;
          r_idx <= '0;
        end
      end
`else
      if (w_pop) begin
        r_buf <= bus.dma_rd_data;
        r_idx <= '0;
      end
`endif
    end
  end

  assign w_en          = (r_state == S_SERIAL) && !rst;
  assign bus.dma_rd_en = w_pop;
  assign bus.mem_en    = w_en;
  assign bus.mem_wr_en = w_en;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_data  = w_en ? w_word : '0;
  assign bus.busy      = (r_state == S_FETCH)
                       || (r_state == S_SERIAL);
  assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_dma_line_unpacker.sv
// Scoreboard bench for dma_line_unpacker: directed transfers,
// monitor compares every accepted memory write against a queue.
module tb_dma_line_unpacker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_line_unpacker_if bus ();
  dma_line_unpacker dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int writes = 0;
  int pops = 0;
  int cyc = 0;
  int first_en = -1;
  int last_en = -1;
  logic [59:0]  sb[$];
  logic [511:0] fifo[$];
  logic bp_mode = 1'b0;
  logic pop_seen = 1'b0;
  logic prev_stall = 1'b0;
  logic [27:0] prev_addr;
  logic [31:0] prev_data;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  function automatic logic [31:0] wd(int s, int k);
    return 32'hA000_0000 + 32'(s * 256 + k);
  endfunction

  function automatic logic [511:0] mk_line(int s);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = wd(s, k);
    return l;
  endfunction

  task automatic exp_lines(input logic [27:0] base,
                           input int n, input int s0);
    logic [27:0] a;
    for (int l = 0; l < n; l++)
      for (int k = 0; k < 16; k++) begin
        a = base + 28'(l * 16 + k);
        sb.push_back({a, wd(s0 + l, k)});
      end
  endtask

  // Ready pattern and show-ahead FIFO model.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (bp_mode)
      bus.mem_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else
      bus.mem_ready = 1'b1;
    #1;
    if (pop_seen && fifo.size() > 0) void'(fifo.pop_front());
    bus.dma_empty = (fifo.size() == 0);
    bus.dma_rd_data = (fifo.size() > 0) ? fifo[0] : '0;
  end

  // Monitor: counts pops, checks writes and stall stability.
  always @(negedge clk) begin
    logic [59:0] e;
    pop_seen = bus.dma_rd_en;
    if (pop_seen) pops++;
    if (!rst) begin
      if (prev_stall) begin
        check("hold_en", bus.mem_en, 1);
        check("hold_addr", bus.mem_addr, prev_addr);
        check("hold_data", bus.mem_data, prev_data);
      end
      if (bus.mem_en) begin
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (bus.mem_en && bus.mem_ready) begin
        writes++;
        check("wr_en_eq", bus.mem_wr_en, 1);
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("wr_addr", bus.mem_addr, e[59:32]);
          check("wr_data", bus.mem_data, e[31:0]);
        end
      end
      prev_stall = bus.mem_en && !bus.mem_ready;
      prev_addr  = bus.mem_addr;
      prev_data  = bus.mem_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic go_pulse(input logic [27:0] base, input int n);
    @(posedge clk);
    #1;
    bus.go = 1'b1;
    bus.base_addr = base;
    bus.num_lines = 27'(n);
    @(posedge clk);
    #1;
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1;
        break;
      end
    end
    check("done_reached", ok, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, p0, w1;
    bit ok;
    bus.go = 1'b0;
    bus.base_addr = '0;
    bus.num_lines = '0;
    bus.dma_empty = 1'b1;
    bus.dma_rd_data = '0;
    bus.mem_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_rd_en", bus.dma_rd_en, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_data", bus.mem_data, 0);

    // Single line, ready high.
    fifo.push_back(mk_line(0));
    exp_lines(28'h100, 1, 0);
    w0 = writes; p0 = pops;
    go_pulse(28'h100, 1);
    wait_done(200);
    check("single_writes", writes - w0, 16);
    check("single_pops", pops - p0, 1);
    check("single_done", bus.done, 1);
    check("single_busy", bus.busy, 0);
    check("single_sb_empty", sb.size(), 0);

    // Backpressure 1,0,0,1.
    bp_mode = 1'b1;
    fifo.push_back(mk_line(1));
    exp_lines(28'h200, 1, 1);
    w0 = writes;
    go_pulse(28'h200, 1);
    wait_done(400);
    bp_mode = 1'b0;
    check("bp_writes", writes - w0, 16);
    check("bp_sb_empty", sb.size(), 0);

    // Three lines with an empty FIFO stall after line 0.
    fifo.push_back(mk_line(2));
    exp_lines(28'h300, 3, 2);
    w0 = writes; p0 = pops;
    go_pulse(28'h300, 3);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (writes - w0 == 16) begin
        ok = 1;
        break;
      end
    end
    check("stall_line0", ok, 1);
    w1 = writes;
    repeat (10) @(negedge clk);
    check("stall_no_writes", writes - w1, 0);
    check("stall_busy", bus.busy, 1);
    check("stall_mem_en", bus.mem_en, 0);
    fifo.push_back(mk_line(3));
    fifo.push_back(mk_line(4));
    wait_done(400);
    check("stall_writes", writes - w0, 48);
    check("stall_pops", pops - p0, 3);

    // Zero length.
    w0 = writes; p0 = pops;
    go_pulse(28'h050, 0);
    @(negedge clk);
    check("zero_done", bus.done, 1);
    check("zero_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    check("zero_writes", writes - w0, 0);
    check("zero_pops", pops - p0, 0);

    // Go while busy is ignored.
    fifo.push_back(mk_line(5));
    fifo.push_back(mk_line(6));
    exp_lines(28'h400, 2, 5);
    w0 = writes; p0 = pops;
    go_pulse(28'h400, 2);
    repeat (3) @(posedge clk);
    #1;
    bus.go = 1'b1;
    bus.base_addr = 28'h999;
    bus.num_lines = 27'd5;
    @(posedge clk);
    #1 bus.go = 1'b0;
    wait_done(400);
    check("ign_writes", writes - w0, 32);
    check("ign_pops", pops - p0, 2);
    check("ign_sb_empty", sb.size(), 0);

    // Address wrap, gap between lines.
    fifo.push_back(mk_line(7));
    fifo.push_back(mk_line(8));
    exp_lines(28'hFFF_FFF8, 2, 7);
    w0 = writes;
    first_en = -1;
    go_pulse(28'hFFF_FFF8, 2);
    wait_done(400);
    check("wrap_writes", writes - w0, 32);
`ifdef UNPACK_PREFETCH_EN
    check("wrap_en_span", last_en - first_en + 1, 32);
`else
    check("wrap_en_span", last_en - first_en + 1, 33);
`endif

    // Reset during word 5.
    fifo.push_back(mk_line(9));
    exp_lines(28'h500, 1, 9);
    w0 = writes; p0 = pops;
    go_pulse(28'h500, 1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_en && bus.mem_addr == 28'h504) begin
        ok = 1;
        break;
      end
    end
    check("mid_word4_seen", ok, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_busy", bus.busy, 0);
    check("mid_done", bus.done, 0);
    check("mid_mem_en", bus.mem_en, 0);
    check("mid_addr", bus.mem_addr, 0);
    check("mid_data", bus.mem_data, 0);
    check("mid_writes", writes - w0, 5);
    fifo.push_back(mk_line(10));
    repeat (6) @(negedge clk);
    check("mid_no_pop", pops - p0, 1);
    fifo.delete();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
